// File: rtl/div_share_ctrl.sv
// Sequencer and two-way round-robin arbiter for a shared combinational divider.
// Handles signed fix-up, divide-by-zero and signed overflow, and holds operands for DIV_LATENCY cycles.
module div_share_ctrl #(
  parameter int WIDTH       = 64,
  parameter int DIV_LATENCY = 1    // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_signed,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_quo,
  output logic [WIDTH-1:0] rsp0_rem,
  output logic             rsp0_dz,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_signed,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_quo,
  output logic [WIDTH-1:0] rsp1_rem,
  output logic             rsp1_dz,

  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_quo,
  input  logic [WIDTH-1:0] div_rem,

  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    SPECIAL = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0]       CNT_LOAD = 4'(DIV_LATENCY - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  state_t           state, state_next;
  logic             last_grant;
  logic             owner;
  logic             grant;
  logic             accept;
  logic             take;

  logic [WIDTH-1:0] sel_a, sel_b, mag_a, mag_b;
  logic             sel_signed, sel_neg_a, sel_neg_b, sel_special;

  logic [WIDTH-1:0] a_q;
  logic             zero_q;
  logic             quo_neg_q;
  logic             rem_neg_q;
  logic [3:0]       cnt_q;

  logic             res_load;
  logic [WIDTH-1:0] res_quo, res_rem;
  logic             res_dz;

  // Round-robin: a lone requester always wins; on a tie the one not granted last wins.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = (state == IDLE) && !grant;
  assign req1_ready = (state == IDLE) &&  grant;
  assign accept     = grant ? (req1_valid && req1_ready) : (req0_valid && req0_ready);

  always_comb begin
    sel_a       = grant ? req1_a      : req0_a;
    sel_b       = grant ? req1_b      : req0_b;
    sel_signed  = grant ? req1_signed : req0_signed;
    sel_neg_a   = sel_signed & sel_a[WIDTH-1];
    sel_neg_b   = sel_signed & sel_b[WIDTH-1];
    mag_a       = sel_neg_a ? (ZERO - sel_a) : sel_a;
    mag_b       = sel_neg_b ? (ZERO - sel_b) : sel_b;
    sel_special = (sel_b == ZERO) ||
                  (sel_signed && (sel_a == MIN_VAL) && (sel_b == ALL_ONES));
  end

  assign take       = (state == DONE) && (owner ? rsp1_ready : rsp0_ready);
  assign rsp0_valid = (state == DONE) && !owner;
  assign rsp1_valid = (state == DONE) &&  owner;
  assign busy       = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = sel_special ? SPECIAL : BUSY;
      BUSY:    if (cnt_q == 4'd0) state_next = DONE;
      SPECIAL: state_next = DONE;
      DONE:    if (take) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result selection: special cases bypass the divider, otherwise undo the magnitude transform.
  always_comb begin
    res_load = 1'b0;
    res_quo  = ZERO;
    res_rem  = ZERO;
    res_dz   = 1'b0;
    if (state == SPECIAL) begin
      res_load = 1'b1;
      if (zero_q) begin
        res_quo = ALL_ONES;
        res_rem = a_q;
        res_dz  = 1'b1;
      end else begin
        res_quo = MIN_VAL;
      end
    end else if ((state == BUSY) && (cnt_q == 4'd0)) begin
      res_load = 1'b1;
      res_quo  = quo_neg_q ? (ZERO - div_quo) : div_quo;
      res_rem  = rem_neg_q ? (ZERO - div_rem) : div_rem;
    end
  end

  // Command capture and the divider operand hold window.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      a_q        <= ZERO;
      zero_q     <= 1'b0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      cnt_q      <= 4'd0;
      div_a      <= ZERO;
      div_b      <= ZERO;
    end else if (accept) begin
      last_grant <= grant;
      owner      <= grant;
      a_q        <= sel_a;
      zero_q     <= (sel_b == ZERO);
      quo_neg_q  <= sel_neg_a ^ sel_neg_b;
      rem_neg_q  <= sel_neg_a;
      cnt_q      <= CNT_LOAD;
      if (!sel_special) begin
        div_a <= mag_a;
        div_b <= mag_b;
      end
    end else if (state == BUSY) begin
      if (cnt_q == 4'd0) begin
        div_a <= ZERO;
        div_b <= ZERO;
      end else begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  // Per-requester response registers; only the owner's set is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_quo <= ZERO;
      rsp0_rem <= ZERO;
      rsp0_dz  <= 1'b0;
      rsp1_quo <= ZERO;
      rsp1_rem <= ZERO;
      rsp1_dz  <= 1'b0;
    end else if (res_load) begin
      if (owner) begin
        rsp1_quo <= res_quo;
        rsp1_rem <= res_rem;
        rsp1_dz  <= res_dz;
      end else begin
        rsp0_quo <= res_quo;
        rsp0_rem <= res_rem;
        rsp0_dz  <= res_dz;
      end
    end
  end

endmodule
